usb_tx_line_encoder: RTL and testbench

Bit-level USB full-speed line encoder that sits directly downstream of the usb_tx packet stage. It takes the packet byte stream (PID, data, CRC) over a valid/ready handshake and drives the bus pins. Its job covers:
- prepending SYNC;
- LSB-first serialisation;
- bit stuffing;
- NRZI encoding;
- appending EOP.
It contains the bit-timing counter, so the upstream stage works purely in bytes.

---
 rtl/usb_tx_line_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_line_encoder.sv
// ----------------------------------------------------------------------------
// usb_tx_line_encoder
//
// Full-speed USB bit-level line encoder. Takes the packet byte stream (PID,
// payload, CRC) from the upstream packet stage and drives D+/D-. It does the
// following:
//   - prepends SYNC;
//   - serialises each byte LSB first;
//   - inserts a stuffed 0 after six consecutive 1s;
//   - NRZI-encodes the result;
//   - appends EOP (two SE0 bit periods, then one J bit period).
// Bit timing is generated here, so the upstream stage only deals in bytes.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   start        one-cycle pulse, begins a packet (only honoured in IDLE)
//   byte_data    next packet byte, sent LSB first
//   byte_valid   byte_data / byte_last are valid
//   byte_last    current byte is the final byte of the packet
//   byte_ready   byte accepted this cycle when byte_valid is also high
//   dplus_out    D+ drive
//   dminus_out   D- drive
//   tx_active    high from the cycle after start through the final EOP J bit
//   tx_done      one-cycle pulse on normal EOP completion
//   tx_error     one-cycle pulse when upstream underruns a byte request
// ----------------------------------------------------------------------------
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;     // position within SYNC or the current byte
    logic [2:0]       ones_cnt;    // consecutive 1s on the wire, including the current bit
    logic [7:0]       shift_reg;   // shift_reg[0] is the data bit now on the line
    logic             last_reg;
    logic             stuffing;    // current bit period carries a stuffed 0
    logic             nrzi_level;  // 1 = J, 0 = K
    logic             eop_second;  // second SE0 bit period in progress
    logic             aborted;

    logic bit_end;
    logic in_payload;
    logic stuff_now;
    logic hs_point;
    logic emit;
    logic tx_bit;
    logic next_level;

    // NOTE: every signal gets a default before the branches so always_comb never infers a latch.
    always_comb begin
        bit_end    = (bit_cnt == CNT_LAST);
        in_payload = (state == SYNC) || (state == DATA);
        // A stuffed 0 follows six 1s; it clears ones_cnt, so it cannot repeat.
        stuff_now  = !stuffing && (ones_cnt == 3'd6);
        // This bit period ends with a byte request: after the final SYNC bit,
        // or after the final bit of a non-last byte, but never while a stuff
        // bit is still owed (the request moves to the stuff bit's end).
        hs_point   = in_payload && !stuff_now && (bit_idx == 3'd7) &&
                     ((state == SYNC) || !last_reg);

        emit   = 1'b0;
        tx_bit = 1'b0;
        if (state == IDLE) begin
            emit = start;                       // first SYNC bit is a 0
        end else if (in_payload && bit_end) begin
            if (stuff_now) begin
                emit = 1'b1;                    // stuffed 0
            end else if (byte_ready) begin
                emit   = byte_valid;
                tx_bit = byte_data[0];
            end else if (state == SYNC) begin
                emit   = 1'b1;
                tx_bit = (bit_idx == 3'd6);     // SYNC is 0000_0001, LSB first
            end else if (bit_idx != 3'd7) begin
                emit   = 1'b1;
                tx_bit = shift_reg[1];
            end
        end
        next_level = tx_bit ? nrzi_level : ~nrzi_level;
    end

    // byte_ready is only ever high on a bit-end cycle, so the abort decision
    // lines up with the handshake cycle itself.
    assign tx_error = byte_ready & ~byte_valid;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            ones_cnt   <= '0;
            shift_reg  <= '0;
            last_reg   <= 1'b0;
            stuffing   <= 1'b0;
            nrzi_level <= 1'b1;
            eop_second <= 1'b0;
            aborted    <= 1'b0;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            byte_ready <= 1'b0;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            // Both pulses are decided one cycle early so they sit on the bit-end cycle.
            byte_ready <= hs_point && (bit_cnt == CNT_PRE);
            tx_done    <= (state == EOP_J) && !aborted && (bit_cnt == CNT_PRE);

            if (state != IDLE) begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            end

            if (emit) begin
                nrzi_level <= next_level;
                dplus_out  <= next_level;
                dminus_out <= ~next_level;
                ones_cnt   <= tx_bit ? ones_cnt + 3'd1 : 3'd0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SYNC;
                        bit_idx   <= '0;
                        stuffing  <= 1'b0;
                        aborted   <= 1'b0;
                        tx_active <= 1'b1;
                    end
                end

                SYNC, DATA: begin
                    if (bit_end) begin
                        if (stuff_now) begin
                            // Insert the stuff period; bit_idx and shift_reg hold.
                            stuffing <= 1'b1;
                        end else begin
                            stuffing <= 1'b0;
                            if (byte_ready) begin
                                if (byte_valid) begin
                                    state     <= DATA;
                                    shift_reg <= byte_data;
                                    last_reg  <= byte_last;
                                    bit_idx   <= '0;
                                end else begin
                                    state      <= EOP_SE0;
                                    eop_second <= 1'b0;
                                    aborted    <= 1'b1;
                                    ones_cnt   <= '0;
                                    dplus_out  <= 1'b0;
                                    dminus_out <= 1'b0;
                                end
                            end else if ((state == SYNC) || (bit_idx != 3'd7)) begin
                                bit_idx <= bit_idx + 3'd1;
                                if (state == DATA) begin
                                    shift_reg <= shift_reg >> 1;
                                end
                            end else begin
                                state      <= EOP_SE0;
                                eop_second <= 1'b0;
                                ones_cnt   <= '0;
                                dplus_out  <= 1'b0;
                                dminus_out <= 1'b0;
                            end
                        end
                    end
                end

                EOP_SE0: begin
                    if (bit_end) begin
                        if (eop_second) begin
                            state      <= EOP_J;
                            dplus_out  <= 1'b1;
                            dminus_out <= 1'b0;
                        end else begin
                            eop_second <= 1'b1;
                        end
                    end
                end

                EOP_J: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        tx_active  <= 1'b0;
                        nrzi_level <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// ----------------------------------------------------------------------------
// tb_usb_tx_line_encoder
//
// Self-checking bench for usb_tx_line_encoder with CLKS_PER_BIT = 8.
// A behavioural model turns each packet into a queue of expected bit
// periods. Each period holds the line symbol plus the ready/done/error pulses
// due on its last cycle. The queue is popped as the DUT runs, and every cycle
// is compared against it.
// ----------------------------------------------------------------------------
module tb_usb_tx_line_encoder;

    localparam int         CPB     = 8;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef struct {
        logic [1:0] sym;
        logic       ready;
        logic       done;
        logic       err;
    } period_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    int n_cmp = 0;
    int n_mis = 0;

    period_t    exp_q[$];
    logic [7:0] pkt_q[$];
    logic       pkt_underrun;
    int         disturb_q[$];
    logic [1:0] obs_q[$];
    logic [1:0] ref_q[$];
    int         done_cycle, err_cycle, se0_cycle, ready_cnt, ready_offedge;
    logic       model_level;
    int         model_ones;

    usb_tx_line_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic push_period(input logic [1:0] sym);
        period_t p;
        p.sym   = sym;
        p.ready = 1'b0;
        p.done  = 1'b0;
        p.err   = 1'b0;
        exp_q.push_back(p);
    endtask

    task automatic mark_last(input logic ready, input logic done, input logic err);
        period_t p;
        p = exp_q.pop_back();
        p.ready = p.ready | ready;
        p.done  = p.done | done;
        p.err   = p.err | err;
        exp_q.push_back(p);
    endtask

    task automatic push_bit(input logic b);
        if (!b) model_level = ~model_level;
        push_period(model_level ? SYM_J : SYM_K);
        model_ones = b ? model_ones + 1 : 0;
        if (model_ones == 6) begin
            model_level = ~model_level;
            push_period(model_level ? SYM_J : SYM_K);
            model_ones = 0;
        end
    endtask

    task automatic build_expected();
        logic [7:0] cur_byte;
        exp_q.delete();
        model_level = 1'b1;
        model_ones  = 0;
        for (int i = 0; i < 8; i++) push_bit(i == 7);
        mark_last(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < pkt_q.size(); j++) begin
            cur_byte = pkt_q[j];
            for (int i = 0; i < 8; i++) push_bit(cur_byte[i]);
            if ((j < pkt_q.size() - 1) || pkt_underrun) mark_last(1'b1, 1'b0, 1'b0);
        end
        if (pkt_underrun) mark_last(1'b0, 1'b0, 1'b1);
        push_period(SYM_SE0);
        push_period(SYM_SE0);
        push_period(SYM_J);
        if (!pkt_underrun) mark_last(1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- driver / monitor ----------------
    task automatic drive_byte(input int idx);
        byte_valid = (idx < pkt_q.size());
        byte_data  = byte_valid ? pkt_q[idx] : 8'h00;
        byte_last  = byte_valid && (idx == pkt_q.size() - 1) && !pkt_underrun;
    endtask

    function automatic logic in_disturb(input int k);
        foreach (disturb_q[i]) if (disturb_q[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_packet();
        int         total;
        int         byte_idx;
        int         ph;
        period_t    cur;
        logic       hs;
        logic [5:0] obs_vec;
        logic [5:0] exp_vec;
        build_expected();
        total = exp_q.size() * CPB;
        obs_q.delete();
        done_cycle    = -1;
        err_cycle     = -1;
        se0_cycle     = -1;
        ready_cnt     = 0;
        ready_offedge = 0;
        byte_idx      = 0;
        drive_byte(byte_idx);
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= total; k++) begin
            start = in_disturb(k);
            ph = (k - 1) % CPB;
            if (ph == 0) cur = exp_q.pop_front();
            @(negedge clk);
            exp_vec = {cur.sym, 1'b1, cur.ready && (ph == CPB - 1),
                       cur.done && (ph == CPB - 1), cur.err && (ph == CPB - 1)};
            obs_vec = {dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error};
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL cycle_%0d {dp,dm,active,ready,done,err}: got %b required %b",
                         k, obs_vec, exp_vec);
            end
            if (ph == CPB / 2) obs_q.push_back({dplus_out, dminus_out});
            if (tx_done && done_cycle < 0) done_cycle = k;
            if (tx_error && err_cycle < 0) err_cycle = k;
            if (({dplus_out, dminus_out} == SYM_SE0) && se0_cycle < 0) se0_cycle = k;
            if (byte_ready) begin
                ready_cnt++;
                if (ph != CPB - 1) ready_offedge++;
            end
            hs = byte_ready && byte_valid;
            @(posedge clk); #1;
            if (hs) begin
                byte_idx++;
                drive_byte(byte_idx);
            end
        end
        start = 1'b0;
        @(negedge clk);
        obs_vec = {dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error};
        n_cmp++;
        if (obs_vec !== 6'b10_0000) begin
            n_mis++;
            $display("FAIL post_packet_idle: got %b required %b", obs_vec, 6'b10_0000);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    function automatic logic [63:0] pack_syms(input logic [1:0] q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[61:0], q[i]};
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] obs_vec;
        int         bad;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        obs_vec = {dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error};
        n_cmp++;
        if (obs_vec !== 6'b10_0000) begin
            n_mis++;
            $display("FAIL reset_state: got %b required %b", obs_vec, 6'b10_0000);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Start a packet and reset it while in DATA (cycle 80 is data bit 1).
        pkt_q = '{8'hA5};
        pkt_underrun = 1'b0;
        drive_byte(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            obs_vec = {dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error};
            n_cmp++;
            if (obs_vec !== 6'b10_0000) begin
                n_mis++;
                $display("FAIL reset_mid_data_%0d: got %b required %b", i, obs_vec, 6'b10_0000);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error} !== 6'b10_0000)
                bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_mis++;
            $display("FAIL reset_hold_j: got %0d non-idle cycles required 0", bad);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic test_single_zero();
        logic [63:0] exp_v;
        pkt_q = '{8'h00};
        pkt_underrun = 1'b0;
        run_packet();
        // SYNC K J K J K J K K, data J K J K J K J K, SE0 SE0, J
        exp_v = 64'(38'b01_10_01_10_01_10_01_01_10_01_10_01_10_01_10_01_00_00_10);
        n_cmp++;
        if (pack_syms(obs_q) !== exp_v) begin
            n_mis++;
            $display("FAIL zero_line_pattern: got %h required %h", pack_syms(obs_q), exp_v);
        end
        n_cmp++;
        if (done_cycle !== 19 * CPB) begin
            n_mis++;
            $display("FAIL zero_done_cycle: got %0d required %0d", done_cycle, 19 * CPB);
        end
        n_cmp++;
        if (se0_cycle !== 16 * CPB + 1) begin
            n_mis++;
            $display("FAIL zero_se0_cycle: got %0d required %0d", se0_cycle, 16 * CPB + 1);
        end
    endtask

    task automatic test_all_ones();
        logic [63:0] exp_v;
        pkt_q = '{8'hFF};
        pkt_underrun = 1'b0;
        run_packet();
        // SYNC, then K x5, stuffed J, J x3, then EOP
        exp_v = 64'(40'b01_10_01_10_01_10_01_01_01_01_01_01_01_10_10_10_10_00_00_10);
        n_cmp++;
        if (pack_syms(obs_q) !== exp_v) begin
            n_mis++;
            $display("FAIL ones_line_pattern: got %h required %h", pack_syms(obs_q), exp_v);
        end
        n_cmp++;
        if (se0_cycle !== (8 + 9) * CPB + 1) begin
            n_mis++;
            $display("FAIL ones_data_length: got SE0 at %0d required %0d", se0_cycle, (8 + 9) * CPB + 1);
        end
        n_cmp++;
        if (done_cycle !== 20 * CPB) begin
            n_mis++;
            $display("FAIL ones_done_cycle: got %0d required %0d", done_cycle, 20 * CPB);
        end
    endtask

    task automatic test_two_bytes();
        logic [1:0]  prev;
        int          ones;
        int          nbits;
        logic [15:0] bits;
        logic        b;
        pkt_q = '{8'hA5, 8'h3C};
        pkt_underrun = 1'b0;
        run_packet();
        ref_q = obs_q;
        n_cmp++;
        if (ready_cnt !== 2 || ready_offedge !== 0) begin
            n_mis++;
            $display("FAIL two_ready_pulses: got %0d (off-edge %0d) required 2 (off-edge 0)",
                     ready_cnt, ready_offedge);
        end
        prev  = obs_q[7];
        ones  = 1;
        nbits = 0;
        bits  = '0;
        for (int i = 8; i < obs_q.size(); i++) begin
            if (obs_q[i] == SYM_SE0) break;
            b = (obs_q[i] == prev);
            prev = obs_q[i];
            if (ones == 6) begin
                ones = 0;
            end else begin
                if (nbits < 16) bits[nbits] = b;
                nbits++;
                ones = b ? ones + 1 : 0;
            end
        end
        n_cmp++;
        if (nbits !== 16 || bits !== 16'h3CA5) begin
            n_mis++;
            $display("FAIL two_decode: got %0d bits value %h required 16 bits value 3ca5", nbits, bits);
        end
        n_cmp++;
        if (done_cycle !== 27 * CPB) begin
            n_mis++;
            $display("FAIL two_done_cycle: got %0d required %0d", done_cycle, 27 * CPB);
        end
    endtask

    task automatic test_underrun();
        pkt_q = '{8'h5A};
        pkt_underrun = 1'b1;
        run_packet();
        pkt_underrun = 1'b0;
        n_cmp++;
        if (err_cycle !== 16 * CPB) begin
            n_mis++;
            $display("FAIL underrun_err_cycle: got %0d required %0d", err_cycle, 16 * CPB);
        end
        n_cmp++;
        if (se0_cycle !== err_cycle + 1) begin
            n_mis++;
            $display("FAIL underrun_se0_next: got %0d required %0d", se0_cycle, err_cycle + 1);
        end
        n_cmp++;
        if (done_cycle !== -1) begin
            n_mis++;
            $display("FAIL underrun_no_done: got tx_done at %0d required none", done_cycle);
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        pkt_q = '{8'hA5, 8'h3C};
        pkt_underrun = 1'b0;
        // 70: DATA; 212: mid EOP_J; 216: the tx_done cycle
        disturb_q = '{70, 212, 216};
        run_packet();
        disturb_q.delete();
        n_cmp++;
        if (pack_syms(obs_q) !== pack_syms(ref_q) || obs_q.size() !== ref_q.size()) begin
            n_mis++;
            $display("FAIL start_ignored_stream: got %h required %h", pack_syms(obs_q), pack_syms(ref_q));
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({dplus_out, dminus_out, tx_active, byte_ready} !== 4'b1000) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_mis++;
            $display("FAIL start_ignored_idle: got %0d active cycles required 0", bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        // 0x7E has six 1s inside the byte, so a stuff bit appears mid-byte.
        pkt_q = '{8'h7E, 8'hFF};
        pkt_underrun = 1'b0;
        run_packet();
        n_cmp++;
        if (done_cycle !== 29 * CPB) begin
            n_mis++;
            $display("FAIL b2b_first_done: got %0d required %0d", done_cycle, 29 * CPB);
        end
        pkt_q = '{8'h00};
        run_packet();
        n_cmp++;
        if (done_cycle !== 19 * CPB || ready_offedge !== 0) begin
            n_mis++;
            $display("FAIL b2b_second_done: got %0d (off-edge ready %0d) required %0d (0)",
                     done_cycle, ready_offedge, 19 * CPB);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        byte_data    = 8'h00;
        byte_valid   = 1'b0;
        byte_last    = 1'b0;
        pkt_underrun = 1'b0;
        test_reset();
        test_single_zero();
        test_all_ones();
        test_two_bytes();
        test_underrun();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
